// File: rtl/maze_move_scheduler.sv
// maze_move_scheduler: frame-synchronous player mover with a wall-store read handshake.
// Optional macro WALL_BYPASS_EN: skip the wall lookup and commit any on-grid move (free roam).
module maze_move_scheduler #(
  parameter int COLS        = 16,
  parameter int ROWS        = 12,
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int VBLANK_LINE = 480,
  parameter int RD_TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [9:0]     i_vcount,
  input  logic           i_move_req,
  input  logic [1:0]     i_move_dir,
  output logic           o_wall_rd_en,
  output logic [X_W-1:0] o_wall_rd_x,
  output logic [Y_W-1:0] o_wall_rd_y,
  input  logic           i_wall_rd_valid,
  input  logic           i_wall_rd_data,
  output logic [X_W-1:0] o_player_x,
  output logic [Y_W-1:0] o_player_y,
  output logic           o_frame_tick,
  output logic           o_move_ack,
  output logic           o_move_blocked,
  output logic           o_busy,
  output logic           o_goal_reached
);

  localparam logic [X_W-1:0]   X_MAX    = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(ROWS - 1);
  localparam logic [9:0]       VB_LINE  = 10'(VBLANK_LINE);
  localparam int               CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_WAIT_RD = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_in_vb, r_in_vb_q, w_vb_edge;
  logic             r_pending, w_pending_nxt;
  logic [1:0]       r_dir, w_dir_nxt;
  logic [X_W-1:0]   r_tgt_x, w_tgt_x_nxt, w_step_x;
  logic [Y_W-1:0]   r_tgt_y, w_tgt_y_nxt, w_step_y;
  logic             w_off_grid;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [X_W-1:0]   r_player_x, w_player_x_nxt;
  logic [Y_W-1:0]   r_player_y, w_player_y_nxt;
  logic             r_goal, w_goal_nxt;
  logic             r_rd_en, w_rd_en_nxt;
  logic [X_W-1:0]   r_rd_x, w_rd_x_nxt;
  logic [Y_W-1:0]   r_rd_y, w_rd_y_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_blocked, w_blocked_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_frame_tick;

  assign w_vb_edge = r_in_vb & ~r_in_vb_q;

  // Candidate target cell for the stored direction; off-grid moves never wrap.
  always_comb begin
    w_step_x   = r_player_x;
    w_step_y   = r_player_y;
    w_off_grid = 1'b0;
    case (r_dir)
      2'd0: begin
        w_off_grid = (r_player_y == {Y_W{1'b0}});
        w_step_y   = r_player_y - Y_W'(1);
      end
      2'd1: begin
        w_off_grid = (r_player_y == Y_MAX);
        w_step_y   = r_player_y + Y_W'(1);
      end
      2'd2: begin
        w_off_grid = (r_player_x == {X_W{1'b0}});
        w_step_x   = r_player_x - X_W'(1);
      end
      2'd3: begin
        w_off_grid = (r_player_x == X_MAX);
        w_step_x   = r_player_x + X_W'(1);
      end
      default: begin
        w_off_grid = 1'b1;
      end
    endcase
  end

  // Next-state and next-output logic of the move sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_dir_nxt      = r_dir;
    w_tgt_x_nxt    = r_tgt_x;
    w_tgt_y_nxt    = r_tgt_y;
    w_cnt_nxt      = r_cnt;
    w_player_x_nxt = r_player_x;
    w_player_y_nxt = r_player_y;
    w_goal_nxt     = r_goal;
    w_rd_en_nxt    = 1'b0;
    w_rd_x_nxt     = r_rd_x;
    w_rd_y_nxt     = r_rd_y;
    w_ack_nxt      = 1'b0;
    w_blocked_nxt  = 1'b0;

    // Requests are only taken while idle; the latest one wins.
    if (i_move_req && (r_state == S_IDLE) && !r_goal) begin
      w_pending_nxt = 1'b1;
      w_dir_nxt     = i_move_dir;
    end else begin
      w_pending_nxt = r_pending;
    end

    case (r_state)
      S_IDLE: begin
        if (r_pending && w_vb_edge) begin
          w_state_nxt = S_LOOKUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (w_off_grid) begin
          w_blocked_nxt = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_tgt_x_nxt = w_step_x;
          w_tgt_y_nxt = w_step_y;
`ifdef WALL_BYPASS_EN
          w_state_nxt = S_COMMIT;
`else
          w_rd_en_nxt = 1'b1;
          w_rd_x_nxt  = w_step_x;
          w_rd_y_nxt  = w_step_y;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = S_WAIT_RD;
`endif
        end
      end
      S_WAIT_RD: begin
        if (i_wall_rd_valid) begin
          if (i_wall_rd_data) begin
            w_blocked_nxt = 1'b1;
            w_pending_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_state_nxt = S_COMMIT;
          end
        end else if (r_cnt == CNT_LAST) begin
          // A silent wall store is treated as a wall.
          w_blocked_nxt = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        w_player_x_nxt = r_tgt_x;
        w_player_y_nxt = r_tgt_y;
        w_ack_nxt      = 1'b1;
        w_pending_nxt  = 1'b0;
        if ((r_tgt_x == X_MAX) && (r_tgt_y == Y_MAX)) begin
          w_goal_nxt = 1'b1;
        end else begin
          w_goal_nxt = r_goal;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_vb      <= 1'b0;
      r_in_vb_q    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_pending    <= 1'b0;
      r_dir        <= 2'd0;
      r_tgt_x      <= {X_W{1'b0}};
      r_tgt_y      <= {Y_W{1'b0}};
      r_cnt        <= {CNT_W{1'b0}};
      r_player_x   <= {X_W{1'b0}};
      r_player_y   <= {Y_W{1'b0}};
      r_goal       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_x       <= {X_W{1'b0}};
      r_rd_y       <= {Y_W{1'b0}};
      r_ack        <= 1'b0;
      r_blocked    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_in_vb      <= (i_vcount >= VB_LINE);
      r_in_vb_q    <= r_in_vb;
      r_frame_tick <= w_vb_edge;
      r_pending    <= w_pending_nxt;
      r_dir        <= w_dir_nxt;
      r_tgt_x      <= w_tgt_x_nxt;
      r_tgt_y      <= w_tgt_y_nxt;
      r_cnt        <= w_cnt_nxt;
      r_player_x   <= w_player_x_nxt;
      r_player_y   <= w_player_y_nxt;
      r_goal       <= w_goal_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_rd_x       <= w_rd_x_nxt;
      r_rd_y       <= w_rd_y_nxt;
      r_ack        <= w_ack_nxt;
      r_blocked    <= w_blocked_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign o_wall_rd_en   = r_rd_en;
  assign o_wall_rd_x    = r_rd_x;
  assign o_wall_rd_y    = r_rd_y;
  assign o_player_x     = r_player_x;
  assign o_player_y     = r_player_y;
  assign o_frame_tick   = r_frame_tick;
  assign o_move_ack     = r_ack;
  assign o_move_blocked = r_blocked;
  assign o_busy         = r_busy;
  assign o_goal_reached = r_goal;

endmodule

// File: tb/tb_maze_move_scheduler.sv
// Self-checking bench for maze_move_scheduler: directed table, corner sequences, random frames
// scored by a transaction-level model of one move per frame.
module tb_maze_move_scheduler;

  localparam int COLS       = 16;
  localparam int ROWS       = 12;
  localparam int RD_TIMEOUT = 15;
  localparam int BLANK_CYC  = 40;
`ifdef WALL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk, rst_n;
  logic [9:0] vcount;
  logic       move_req;
  logic [1:0] move_dir;
  logic       wall_rd_en, wall_valid, wall_data;
  logic [3:0] wall_rd_x, player_x;
  logic [3:0] wall_rd_y, player_y;
  logic       frame_tick, move_ack, move_blocked, busy, goal_reached;

  maze_move_scheduler dut (
    .clk(clk), .rst_n(rst_n), .i_vcount(vcount), .i_move_req(move_req), .i_move_dir(move_dir),
    .o_wall_rd_en(wall_rd_en), .o_wall_rd_x(wall_rd_x), .o_wall_rd_y(wall_rd_y),
    .i_wall_rd_valid(wall_valid), .i_wall_rd_data(wall_data),
    .o_player_x(player_x), .o_player_y(player_y), .o_frame_tick(frame_tick),
    .o_move_ack(move_ack), .o_move_blocked(move_blocked), .o_busy(busy),
    .o_goal_reached(goal_reached)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int checks = 0, failures = 0;
  // wall store behaviour, set by the stimulus
  int rd_lat = 1;
  bit withhold = 1'b0, force_wall = 1'b0, use_maze = 1'b0;
  int spur_seq = 0;
  bit maze [COLS*ROWS];
  // monitor counters
  int cyc = 0, tick_cnt = 0, ack_cnt = 0, blk_cnt = 0, rd_cnt = 0;
  int tick_cyc = 0, ack_cyc = 0, mon_rd_x = 0, mon_rd_y = 0;
  // reference model state
  int m_x = 0, m_y = 0, m_dir = 0;
  bit m_pending = 1'b0, m_goal = 1'b0;

  typedef struct {
    int dir; int lat; int hold; int wall;
    int ex; int ey; int eack; int eblk; int erd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wall store: answers each strobe rd_lat cycles later unless withheld; optional stray valids.
  initial begin : responder
    int cnt, seen_spur, req_x, req_y;
    bit pend;
    cnt = 0; seen_spur = 0; req_x = 0; req_y = 0; pend = 1'b0;
    wall_valid = 1'b0; wall_data = 1'b0;
    forever begin
      @(negedge clk);
      wall_valid = 1'b0;
      wall_data  = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend = 1'b0;
          if (!withhold) begin
            wall_valid = 1'b1;
            wall_data  = use_maze ? maze[req_y*COLS + req_x] : force_wall;
          end
        end
      end
      if (spur_seq != seen_spur) begin
        seen_spur  = spur_seq;
        wall_valid = 1'b1;
        wall_data  = 1'($urandom_range(0, 1));
      end
      if (wall_rd_en) begin
        pend  = 1'b1;
        cnt   = rd_lat;
        req_x = int'(wall_rd_x);
        req_y = int'(wall_rd_y);
      end
    end
  end

  // Pulse counting; the player must only move while blanking.
  initial begin : monitor
    int px, py;
    px = 0; py = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_tick) begin tick_cnt++; tick_cyc = cyc; end
      if (move_ack) begin ack_cnt++; ack_cyc = cyc; end
      if (move_blocked) blk_cnt++;
      if (wall_rd_en) begin
        rd_cnt++;
        mon_rd_x = int'(wall_rd_x);
        mon_rd_y = int'(wall_rd_y);
      end
      if (rst_n && ((int'(player_x) != px) || (int'(player_y) != py)))
        chk("player_moves_only_in_blank", int'(vcount >= 10'd480), 1);
      px = int'(player_x);
      py = int'(player_y);
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_x = 0; m_y = 0; m_pending = 1'b0; m_goal = 1'b0; m_dir = 0;
  endtask

  task automatic pulse_req(input logic [1:0] d);
    @(negedge clk);
    move_req = 1'b1;
    move_dir = d;
    @(negedge clk);
    move_req = 1'b0;
    if (!m_goal) begin
      m_pending = 1'b1;
      m_dir     = int'(d);
    end
  endtask

  // One frame: requests during visible lines, then a blanking interval with a jittering vCount.
  task automatic run_frame(input int nreq, input logic [1:0] d0, input logic [1:0] d1,
                           output int dack, output int dblk, output int drd,
                           output int dtick, output int dlat);
    int a0, b0, r0, t0;
    vcount = 10'($urandom_range(0, 479));
    repeat (3) @(negedge clk);
    for (int i = 0; i < nreq; i++) begin
      pulse_req((i == 0) ? d0 : d1);
      repeat (2) @(negedge clk);
    end
    a0 = ack_cnt; b0 = blk_cnt; r0 = rd_cnt; t0 = tick_cnt;
    vcount = 10'(480 + $urandom_range(0, 44));
    for (int i = 0; i < BLANK_CYC; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) vcount = 10'(480 + $urandom_range(0, 44));
    end
    vcount = 10'($urandom_range(0, 479));
    repeat (2) @(negedge clk);
    dack  = ack_cnt - a0;
    dblk  = blk_cnt - b0;
    drd   = rd_cnt - r0;
    dtick = tick_cnt - t0;
    dlat  = (dack > 0) ? (ack_cyc - tick_cyc) : -1;
  endtask

  // Frame outcome from the rules: one pending move, edge check, then wall/timeout verdict.
  task automatic predict(input int lat, input bit hold, input bit wall_in, input bit use_m,
                         output int eack, output int eblk, output int erd,
                         output int etx, output int ety);
    eack = 0; eblk = 0; erd = 0; etx = 0; ety = 0;
    if (m_pending) begin
      int tx, ty;
      tx = m_x; ty = m_y;
      case (m_dir)
        0: ty = m_y - 1;
        1: ty = m_y + 1;
        2: tx = m_x - 1;
        default: tx = m_x + 1;
      endcase
      m_pending = 1'b0;
      if (tx < 0 || tx >= COLS || ty < 0 || ty >= ROWS) begin
        eblk = 1;
      end else if (BYP) begin
        eack = 1;
      end else begin
        erd = 1; etx = tx; ety = ty;
        // the store has the strobe cycle plus RD_TIMEOUT-1 further cycles to answer
        if (hold || lat >= RD_TIMEOUT) eblk = 1;
        else if (use_m ? maze[ty*COLS + tx] : wall_in) eblk = 1;
        else eack = 1;
      end
      if (eack != 0) begin
        m_x = tx; m_y = ty;
        if (tx == COLS-1 && ty == ROWS-1) m_goal = 1'b1;
      end
    end
  endtask

  task automatic frame_and_check(input int nreq, input logic [1:0] d0, input logic [1:0] d1,
                                 input int lat, input bit hold, input bit wall_in, input bit use_m);
    int dack, dblk, drd, dtick, dlat, eack, eblk, erd, etx, ety;
    rd_lat = lat; withhold = hold; force_wall = wall_in; use_maze = use_m;
    run_frame(nreq, d0, d1, dack, dblk, drd, dtick, dlat);
    predict(lat, hold, wall_in, use_m, eack, eblk, erd, etx, ety);
    chk("frame_ack", dack, eack);
    chk("frame_blocked", dblk, eblk);
    chk("frame_rd_en", drd, erd);
    chk("frame_tick_once", dtick, 1);
    chk("frame_player_x", int'(player_x), m_x);
    chk("frame_player_y", int'(player_y), m_y);
    chk("frame_goal", int'(goal_reached), int'(m_goal));
    chk("frame_idle_busy", int'(busy), 0);
    if (erd != 0 && drd == 1) begin
      chk("frame_rd_x", mon_rd_x, etx);
      chk("frame_rd_y", mon_rd_y, ety);
    end
    if (eack != 0 && dack == 1) chk("frame_commit_latency", dlat, BYP ? 2 : 3 + lat);
  endtask

  initial begin : main
    int dack, dblk, drd, dtick, dlat, eack, eblk, erd, etx, ety, a0, b0, t0;
    bit seen;
    rst_n = 1'b0; vcount = 10'd0; move_req = 1'b0; move_dir = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_player_x", int'(player_x), 0);
    chk("reset_player_y", int'(player_y), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack", int'(move_ack), 0);
    chk("reset_blocked", int'(move_blocked), 0);
    chk("reset_goal", int'(goal_reached), 0);
    chk("reset_rd_en", int'(wall_rd_en), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);

    // directed table: {dir, lat, hold, wall, exp x, exp y, exp ack, exp blocked, exp reads}
`ifdef WALL_BYPASS_EN
    tbl.push_back(vec_t'{3, 2, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 2, 0, 0, 1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{1, 2, 0, 1, 1, 1, 1, 0, 0});
    tbl.push_back(vec_t'{2, 1, 1, 0, 0, 1, 1, 0, 0});
    tbl.push_back(vec_t'{2, 1, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back(vec_t'{0, 3, 0, 0, 0, 0, 1, 0, 0});
`else
    tbl.push_back(vec_t'{3, 2, 0, 0, 1, 0, 1, 0, 1});
    tbl.push_back(vec_t'{0, 2, 0, 0, 1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{1, 2, 0, 1, 1, 0, 0, 1, 1});
    tbl.push_back(vec_t'{1, 2, 1, 0, 1, 0, 0, 1, 1});
    tbl.push_back(vec_t'{1, 14, 0, 0, 1, 1, 1, 0, 1});
    tbl.push_back(vec_t'{2, 1, 0, 0, 0, 1, 1, 0, 1});
    tbl.push_back(vec_t'{2, 1, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back(vec_t'{1, 15, 0, 0, 0, 1, 0, 1, 1});
    tbl.push_back(vec_t'{0, 3, 0, 0, 0, 0, 1, 0, 1});
`endif
    foreach (tbl[i]) begin
      rd_lat = tbl[i].lat; withhold = 1'(tbl[i].hold);
      force_wall = 1'(tbl[i].wall); use_maze = 1'b0;
      run_frame(1, 2'(tbl[i].dir), 2'd0, dack, dblk, drd, dtick, dlat);
      predict(rd_lat, withhold, force_wall, 1'b0, eack, eblk, erd, etx, ety);
      chk("tbl_ack", dack, tbl[i].eack);
      chk("tbl_blocked", dblk, tbl[i].eblk);
      chk("tbl_rd_en", drd, tbl[i].erd);
      chk("tbl_player_x", int'(player_x), tbl[i].ex);
      chk("tbl_player_y", int'(player_y), tbl[i].ey);
      if (tbl[i].eack != 0 && dack == 1) chk("tbl_latency", dlat, BYP ? 2 : 3 + tbl[i].lat);
    end

    // last request wins: right then down commits only the down move
    frame_and_check(2, 2'd3, 2'd1, 1, 1'b0, 1'b0, 1'b0);

    // request in the vb_edge cycle with nothing pending waits for the next frame
    rd_lat = 1; withhold = 1'b0; force_wall = 1'b0; use_maze = 1'b0;
    vcount = 10'd200;
    repeat (3) @(negedge clk);
    vcount = 10'd480;
    @(negedge clk);
    move_req = 1'b1; move_dir = 2'd0;
    @(negedge clk);
    move_req = 1'b0;
    m_pending = 1'b1; m_dir = 0;
    a0 = ack_cnt; b0 = blk_cnt;
    repeat (BLANK_CYC) @(negedge clk);
    chk("edge_req_deferred_ack", ack_cnt - a0, 0);
    chk("edge_req_deferred_blocked", blk_cnt - b0, 0);
    frame_and_check(0, 2'd0, 2'd0, 1, 1'b0, 1'b0, 1'b0);

    // stray read-valid while idle is ignored
    a0 = ack_cnt; b0 = blk_cnt;
    spur_seq++;
    repeat (4) @(negedge clk);
    chk("stray_valid_ack", ack_cnt - a0, 0);
    chk("stray_valid_blocked", blk_cnt - b0, 0);
    chk("stray_valid_busy", int'(busy), 0);

    // reset during WAIT_RD discards the outstanding read
    rd_lat = 6; withhold = 1'b0; force_wall = 1'b0; use_maze = 1'b0;
    vcount = 10'd100;
    repeat (2) @(negedge clk);
    pulse_req(2'd3);
    vcount = 10'd480;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (wall_rd_en) seen = 1'b1;
    end
    chk("midreset_rd_issued", int'(seen), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy_in_reset", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_x = 0; m_y = 0; m_pending = 1'b0; m_goal = 1'b0;
    a0 = ack_cnt; b0 = blk_cnt;
    repeat (20) @(negedge clk);
    chk("midreset_no_ack", ack_cnt - a0, 0);
    chk("midreset_no_blocked", blk_cnt - b0, 0);
    chk("midreset_player_x", int'(player_x), 0);
    chk("midreset_busy", int'(busy), 0);

    // frame_tick once per 525-line frame (short lines)
    t0 = tick_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 525; l++) begin
        vcount = 10'(l);
        repeat (4) @(negedge clk);
      end
    end
    vcount = 10'd0;
    @(negedge clk);
    chk("ticks_per_525_lines", tick_cnt - t0, 2);

    // random frames against the model
    do_reset();
    for (int i = 0; i < COLS*ROWS; i++) maze[i] = ($urandom_range(0, 3) == 0);
    for (int f = 0; f < 120; f++) begin
      frame_and_check(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), int'($urandom_range(1, 16)),
                      ($urandom_range(0, 9) == 0), 1'b0, 1'b1);
    end

    // walk to the goal cell, then requests are ignored
    do_reset();
    for (int i = 0; i < COLS-1; i++) frame_and_check(1, 2'd3, 2'd0, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ROWS-1; i++) frame_and_check(1, 2'd1, 2'd0, 1, 1'b0, 1'b0, 1'b0);
    chk("goal_set", int'(goal_reached), 1);
    chk("goal_x", int'(player_x), COLS-1);
    chk("goal_y", int'(player_y), ROWS-1);
    frame_and_check(1, 2'd0, 2'd0, 1, 1'b0, 1'b0, 1'b0);
    frame_and_check(2, 2'd2, 2'd0, 1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
